// File: rtl/clk_div_pkg.sv
// Shared types for the divider reconfiguration sequencer.
package clk_div_pkg;

    localparam int unsigned DEFAULT_TIMEOUT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        GATE,
        LOAD,
        WAIT_DONE,
        UNGATE
    } clk_div_cfg_state_e;

endpackage

// File: rtl/clk_div_cfg_ctrl.sv
// Sequences divider reconfiguration: gates the divided clock, hands the registered
// value to clk_int_div_simple, then ungates on done or on timeout.
module clk_div_cfg_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned                DIV_VALUE_WIDTH = 32,
    parameter logic [DIV_VALUE_WIDTH-1:0] DIV_RESET       = DIV_VALUE_WIDTH'(1),
    parameter int unsigned                GATE_DLY        = 2,
    parameter int unsigned                TIMEOUT_WIDTH   = DEFAULT_TIMEOUT_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [DIV_VALUE_WIDTH-1:0] cfg_div_i,
    input  logic                       cfg_init_i,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    output logic [DIV_VALUE_WIDTH-1:0] div_o,
    output logic                       clk_init_o,
    output logic                       div_valid_o,
    input  logic                       div_ready_i,
    input  logic                       div_done_i,
    output logic                       clk_en_o,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int unsigned              GATE_CNT_W = 4;
    localparam logic [GATE_CNT_W-1:0]    GATE_LAST  = GATE_CNT_W'(GATE_DLY - 1);

    clk_div_cfg_state_e           state_q, state_d;
    logic [DIV_VALUE_WIDTH-1:0]   div_q, div_d;
    logic                         clk_init_q, clk_init_d;
    logic                         div_valid_q, div_valid_d;
    logic                         clk_en_q, clk_en_d;
    logic                         err_q, err_d;
    logic [GATE_CNT_W-1:0]        gate_cnt_q, gate_cnt_d;
    logic [TIMEOUT_WIDTH-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                         same_cfg;

    assign same_cfg = (cfg_div_i == div_q) && (cfg_init_i == clk_init_q);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        clk_init_d  = clk_init_q;
        div_valid_d = div_valid_q;
        clk_en_d    = clk_en_q;
        err_d       = err_q;
        gate_cnt_d  = gate_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        cfg_ready_o = 1'b0;
        busy_o      = 1'b1;

        case (state_q)
            IDLE: begin
                cfg_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cfg_valid_i) begin
                    err_d = 1'b0;
                    if (!same_cfg) begin
                        div_d      = cfg_div_i;
                        clk_init_d = cfg_init_i;
                        clk_en_d   = 1'b0;
                        gate_cnt_d = '0;
                        state_d    = GATE;
                    end
                end
            end
            GATE: begin
                if (gate_cnt_q == GATE_LAST) begin
                    div_valid_d = 1'b1;
                    gate_cnt_d  = '0;
                    state_d     = LOAD;
                end else begin
                    gate_cnt_d = gate_cnt_q + 1'b1;
                end
            end
            LOAD: begin
                if (div_ready_i) begin
                    div_valid_d = 1'b0;
                    tmo_cnt_d   = '0;
                    // A zero divider runs in bypass and never raises done.
                    state_d     = (div_q == '0) ? UNGATE : WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                tmo_cnt_d = (&tmo_cnt_q) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
                // Counter still zero marks the first cycle, where done is stale.
                if (div_done_i && (tmo_cnt_q != '0)) begin
                    state_d = UNGATE;
                end else if (&tmo_cnt_d) begin
                    err_d   = 1'b1;
                    state_d = UNGATE;
                end
            end
            UNGATE: begin
                clk_en_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = GATE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= GATE;
            div_q       <= DIV_RESET;
            clk_init_q  <= 1'b0;
            div_valid_q <= 1'b0;
            clk_en_q    <= 1'b0;
            err_q       <= 1'b0;
            gate_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            clk_init_q  <= clk_init_d;
            div_valid_q <= div_valid_d;
            clk_en_q    <= clk_en_d;
            err_q       <= err_d;
            gate_cnt_q  <= gate_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign div_o       = div_q;
    assign clk_init_o  = clk_init_q;
    assign div_valid_o = div_valid_q;
    assign clk_en_o    = clk_en_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Bench for clk_div_cfg_ctrl: a divider responder with a load scoreboard plus per-scenario tasks.
module tb_clk_div_cfg_ctrl;

    localparam int unsigned DW       = 32;
    localparam int unsigned GDLY     = 2;
    localparam int unsigned TW       = 4;
    localparam int          DONE_LAT = 3;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic [DW-1:0] cfg_div_i;
    logic          cfg_init_i;
    logic          cfg_valid_i;
    logic          cfg_ready_o;
    logic [DW-1:0] div_o;
    logic          clk_init_o;
    logic          div_valid_o;
    logic          div_ready_i;
    logic          div_done_i;
    logic          clk_en_o;
    logic          busy_o;
    logic          err_o;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         hs_cyc = -100;
    int         done_set_cyc = -100;
    int         rsp_cnt = 0;
    bit         tie_done_low = 1'b0;
    logic [DW:0] sb_q[$];

    clk_div_cfg_ctrl #(
        .DIV_VALUE_WIDTH(DW),
        .DIV_RESET      (DW'(1)),
        .GATE_DLY       (GDLY),
        .TIMEOUT_WIDTH  (TW)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .cfg_div_i  (cfg_div_i),
        .cfg_init_i (cfg_init_i),
        .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o),
        .div_o      (div_o),
        .clk_init_o (clk_init_o),
        .div_valid_o(div_valid_o),
        .div_ready_i(div_ready_i),
        .div_done_i (div_done_i),
        .clk_en_o   (clk_en_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Divider model: checks each load against the scoreboard, holds the stale done
    // through the first post-handshake cycle, then drops it and raises it later.
    always begin
        logic [DW:0] exp;
        @(negedge clk_i);
        #1;
        if (!rst_n_i) begin
            rsp_cnt = 0;
        end else if (div_valid_o && div_ready_i) begin
            hs_cyc = cyc;
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL load_unexpected: got div=%0d init=%0b, none expected", div_o, clk_init_o);
            end else begin
                exp = sb_q.pop_front();
                if ({clk_init_o, div_o} !== exp) begin
                    n_err++;
                    $display("FAIL load_value: got div=%0d init=%0b expected div=%0d init=%0b",
                             div_o, clk_init_o, exp[DW-1:0], exp[DW]);
                end
            end
            rsp_cnt = 1;
        end else if (rsp_cnt != 0) begin
            rsp_cnt++;
            if (rsp_cnt >= 3 && rsp_cnt <= 2 + DONE_LAT) begin
                div_done_i = 1'b0;
            end else if (rsp_cnt == 3 + DONE_LAT) begin
                div_done_i = 1'b1;
                if (!tie_done_low) done_set_cyc = cyc;
                rsp_cnt = 0;
            end
        end
        if (tie_done_low) div_done_i = 1'b0;
    end

    task automatic wait_idle(input string name, input int budget,
                             output int en_rise, output int err_rise);
        bit ok = 1'b0;
        en_rise  = -1;
        err_rise = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (clk_en_o && en_rise < 0) en_rise = cyc;
            if (err_o && err_rise < 0) err_rise = cyc;
            if (cfg_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s_idle_timeout: got busy after %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic request(input logic [DW-1:0] d, input logic init, input bit push);
        cfg_div_i   = d;
        cfg_init_i  = init;
        cfg_valid_i = 1'b1;
        if (push) sb_q.push_back({init, d});
    endtask

    task automatic test_reset();
        int n = 0;
        int en_r, err_r;
        repeat (2) @(negedge clk_i);
        n_vec++;
        if ({div_o, clk_init_o, div_valid_o, clk_en_o, cfg_ready_o, busy_o, err_o} !==
            {DW'(1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: got div=%0d init=%b v=%b en=%b rdy=%b busy=%b err=%b required 1 0 0 0 0 1 0",
                     div_o, clk_init_o, div_valid_o, clk_en_o, cfg_ready_o, busy_o, err_o);
        end
        sb_q.push_back({1'b0, DW'(1)});
        rst_n_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            n++;
            if (div_valid_o) break;
        end
        n_vec++;
        if (n != GDLY) begin
            n_err++;
            $display("FAIL reset_valid_delay: got %0d cycles, required %0d", n, GDLY);
        end
        @(negedge clk_i);
        n_vec++;
        if (div_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_valid_hold: got %b required 1", div_valid_o);
        end
        div_ready_i = 1'b1;
        wait_idle("reset", 40, en_r, err_r);
        n_vec++;
        if (en_r != done_set_cyc + 2 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ungate: got en_rise=%0d busy=%b err=%b required en_rise=%0d busy=0 err=0",
                     en_r, busy_o, err_o, done_set_cyc + 2);
        end
    endtask

    task automatic test_new_value();
        int  n = 0;
        bit  stable = 1'b1;
        int  en_r, err_r;
        request(DW'(3), 1'b0, 1'b1);
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        n++;
        n_vec++;
        if ({clk_en_o, cfg_ready_o, busy_o, div_o} !== {1'b0, 1'b0, 1'b1, DW'(3)}) begin
            n_err++;
            $display("FAIL new_accept: got en=%b rdy=%b busy=%b div=%0d required 0 0 1 3",
                     clk_en_o, cfg_ready_o, busy_o, div_o);
        end
        while (!div_valid_o && n < 10) begin
            @(negedge clk_i);
            n++;
            if (div_o !== DW'(3)) stable = 1'b0;
        end
        n_vec++;
        if (n != 1 + GDLY) begin
            n_err++;
            $display("FAIL new_valid_latency: got %0d required %0d", n, 1 + GDLY);
        end
        wait_idle("new", 40, en_r, err_r);
        if (div_o !== DW'(3)) stable = 1'b0;
        n_vec++;
        if (!stable) begin
            n_err++;
            $display("FAIL new_div_stable: got change, required div_o=3 throughout");
        end
        n_vec++;
        if (en_r != done_set_cyc + 2 || err_o !== 1'b0) begin
            n_err++;
            $display("FAIL new_ungate: got en_rise=%0d err=%b required en_rise=%0d err=0",
                     en_r, err_o, done_set_cyc + 2);
        end
    endtask

    task automatic test_same_value();
        bit quiet = 1'b1;
        request(DW'(3), 1'b0, 1'b0);
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        n_vec++;
        if ({cfg_ready_o, busy_o, clk_en_o} !== 3'b101) begin
            n_err++;
            $display("FAIL same_accept: got rdy=%b busy=%b en=%b required 1 0 1", cfg_ready_o, busy_o, clk_en_o);
        end
        repeat (5) begin
            @(negedge clk_i);
            if (div_valid_o || !clk_en_o) quiet = 1'b0;
        end
        n_vec++;
        if (!quiet) begin
            n_err++;
            $display("FAIL same_quiet: got handshake or gating, required none");
        end
    endtask

    task automatic test_bypass();
        int en_r, err_r;
        tie_done_low = 1'b1;
        request(DW'(0), 1'b1, 1'b1);
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        wait_idle("bypass", 60, en_r, err_r);
        n_vec++;
        if (en_r != hs_cyc + 2 || err_o !== 1'b0) begin
            n_err++;
            $display("FAIL bypass_ungate: got en_rise=%0d err=%b required en_rise=%0d err=0",
                     en_r, err_o, hs_cyc + 2);
        end
        tie_done_low = 1'b0;
    endtask

    task automatic test_timeout();
        int en_r, err_r;
        tie_done_low = 1'b1;
        request(DW'(5), 1'b0, 1'b1);
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        wait_idle("timeout", 80, en_r, err_r);
        n_vec++;
        if (err_r != hs_cyc + 16 || err_o !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_err: got err_rise=%0d err=%b required err_rise=%0d err=1",
                     err_r, err_o, hs_cyc + 16);
        end
        n_vec++;
        if (en_r != hs_cyc + 17) begin
            n_err++;
            $display("FAIL timeout_ungate: got en_rise=%0d required %0d", en_r, hs_cyc + 17);
        end
        tie_done_low = 1'b0;
        request(DW'(7), 1'b1, 1'b1);
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        n_vec++;
        if (err_o !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_err_clear: got %b required 0", err_o);
        end
        wait_idle("timeout_next", 40, en_r, err_r);
    endtask

    task automatic test_back_to_back();
        bit rdy_ok = 1'b1;
        int accepts = 0;
        int en_r, err_r;
        request(DW'(9), 1'b0, 1'b1);
        @(negedge clk_i);
        request(DW'(10), 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (cfg_ready_o !== ~busy_o) rdy_ok = 1'b0;
            if (cfg_ready_o) begin
                sb_q.push_back({1'b1, DW'(10)});
                accepts++;
                break;
            end
            @(negedge clk_i);
        end
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        n_vec++;
        if (!rdy_ok || accepts != 1 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_backpressure: got rdy_ok=%b accepts=%0d busy=%b required 1 1 1",
                     rdy_ok, accepts, busy_o);
        end
        wait_idle("b2b", 60, en_r, err_r);
        n_vec++;
        if (sb_q.size() != 0 || div_o !== DW'(10)) begin
            n_err++;
            $display("FAIL b2b_drain: got pending=%0d div=%0d required 0 10", sb_q.size(), div_o);
        end
    endtask

    task automatic test_reset_mid();
        int en_r, err_r;
        div_ready_i = 1'b0;
        request(DW'(12), 1'b0, 1'b1);
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        for (int i = 0; i < 10 && !div_valid_o; i++) @(negedge clk_i);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        n_vec++;
        if ({div_o, clk_init_o, div_valid_o, clk_en_o, cfg_ready_o, busy_o, err_o} !==
            {DW'(1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL midreset_values: got div=%0d init=%b v=%b en=%b rdy=%b busy=%b err=%b required 1 0 0 0 0 1 0",
                     div_o, clk_init_o, div_valid_o, clk_en_o, cfg_ready_o, busy_o, err_o);
        end
        sb_q.delete();
        sb_q.push_back({1'b0, DW'(1)});
        rst_n_i     = 1'b1;
        div_ready_i = 1'b1;
        wait_idle("midreset", 40, en_r, err_r);
        n_vec++;
        if (sb_q.size() != 0 || div_o !== DW'(1) || clk_en_o !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_reload: got pending=%0d div=%0d en=%b required 0 1 1",
                     sb_q.size(), div_o, clk_en_o);
        end
    endtask

    initial begin
        rst_n_i     = 1'b0;
        cfg_div_i   = '0;
        cfg_init_i  = 1'b0;
        cfg_valid_i = 1'b0;
        div_ready_i = 1'b0;
        div_done_i  = 1'b1;
        test_reset();
        test_new_value();
        test_same_value();
        test_bypass();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required finish");
        $fatal(1);
    end

endmodule
